// File: rtl/prog_timer_pkg.sv
// Shared types and encodings for the programmable tick timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/prog_timer.sv
// Programmable tick timer: loadable period, up/down, periodic or one-shot, pause or clear on disable.
// Latency: all outputs registered; a load or a start from IDLE takes effect on the next clk_i edge.
// Backpressure: none; tick_o is a one-cycle strobe that downstream must take when it fires.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int unsigned      WIDTH          = 32,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(25000000)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic             hold_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic             step_dir;
  logic             step_mode;
  logic [WIDTH-1:0] step_from;
  logic [WIDTH-1:0] step_count;
  logic             step_term;

  // Counting begins here: 0 going up, the period going down.
  function automatic logic [WIDTH-1:0] start_val(input logic dir, input logic [WIDTH-1:0] per);
    return (dir == DIR_DOWN) ? per : '0;
  endfunction

  // Counting ends here: the period going up, 0 going down.
  function automatic logic [WIDTH-1:0] term_val(input logic dir, input logic [WIDTH-1:0] per);
    return (dir == DIR_DOWN) ? '0 : per;
  endfunction

  // One counting step; a fresh start from IDLE steps from the start value under the incoming dir/mode.
  always_comb begin
    step_dir   = dir_q;
    step_mode  = mode_q;
    step_from  = count_q;
    step_count = count_q;
    if (state_q == IDLE) begin
      step_dir  = dir_i;
      step_mode = mode_i;
      step_from = start_val(dir_i, period_q);
    end
    step_term = (step_from == term_val(step_dir, period_q));
    if (step_term) begin
      step_count = (step_mode == MODE_ONESHOT) ? step_from : start_val(step_dir, period_q);
    end else if (step_dir == DIR_DOWN) begin
      step_count = step_from - 1'b1;
    end else begin
      step_count = step_from + 1'b1;
    end
  end

  // Next-state and datapath selection; load_i overrides everything else.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = done_q;
    if (load_i) begin
      period_d = period_i;
      dir_d    = dir_i;
      mode_d   = mode_i;
      count_d  = start_val(dir_i, period_i);
      done_d   = 1'b0;
      state_d  = enable_i ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE, RUN, PAUSE: begin
          if (enable_i) begin
            if (state_q == IDLE) begin
              dir_d  = dir_i;
              mode_d = mode_i;
            end
            count_d = step_count;
            tick_d  = step_term;
            if (step_term && (step_mode == MODE_ONESHOT)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else if ((state_q == RUN) && hold_i) begin
            state_d = PAUSE;
          end else if ((state_q != IDLE) && !hold_i) begin
            state_d = IDLE;
            count_d = start_val(dir_q, period_q);
          end
        end
        DONE: begin
          if (!enable_i && !hold_i) begin
            state_d = IDLE;
            done_d  = 1'b0;
            count_d = start_val(dir_q, period_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, count, settings and output flags; reset clears outputs without waiting for a clock.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= DEFAULT_PERIOD;
      dir_q    <= DIR_UP;
      mode_q   <= MODE_PERIODIC;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == RUN);

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer (WIDTH=8, DEFAULT_PERIOD=4).
// Table-driven directed vectors, hand-written corner sequences, then randomized traffic vs a model.
// The model tracks elapsed steps within the period rather than the raw count.
module tb_prog_timer;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic         enable_i;
  logic         load_i;
  logic [W-1:0] period_i;
  logic         dir_i;
  logic         mode_i;
  logic         hold_i;
  logic [W-1:0] count_o;
  logic         tick_o;
  logic         done_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  prog_timer #(.WIDTH(W), .DEFAULT_PERIOD(8'd4)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .enable_i (enable_i),
    .load_i   (load_i),
    .period_i (period_i),
    .dir_i    (dir_i),
    .mode_i   (mode_i),
    .hold_i   (hold_i),
    .count_o  (count_o),
    .tick_o   (tick_o),
    .done_o   (done_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Directed vector: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] per;
    logic       dir;
    logic       mode;
    logic       hold;
    int         cnt;
    logic       tick;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  // Reference model: period, settings, steps elapsed in the current period, and activity flags.
  int   m_period;
  logic m_dir, m_mode;
  int   m_elapsed;
  logic m_run, m_paused, m_done, m_tick;

  function automatic void add(int en, int ld, int per, int dir, int mode, int hold,
                              int cnt, int tick, int done, int busy);
    vec_t v;
    v.en   = (en != 0);
    v.ld   = (ld != 0);
    v.per  = 8'(per);
    v.dir  = (dir != 0);
    v.mode = (mode != 0);
    v.hold = (hold != 0);
    v.cnt  = cnt;
    v.tick = (tick != 0);
    v.done = (done != 0);
    v.busy = (busy != 0);
    vecs.push_back(v);
  endfunction

  task automatic model_reset();
    m_period  = 4;
    m_dir     = 1'b0;
    m_mode    = 1'b0;
    m_elapsed = 0;
    m_run     = 1'b0;
    m_paused  = 1'b0;
    m_done    = 1'b0;
    m_tick    = 1'b0;
  endtask

  task automatic model_edge();
    m_tick = 1'b0;
    if (load_i) begin
      m_period  = int'(period_i);
      m_dir     = dir_i;
      m_mode    = mode_i;
      m_elapsed = 0;
      m_done    = 1'b0;
      m_paused  = 1'b0;
      m_run     = enable_i;
    end else if (m_done) begin
      if (!enable_i && !hold_i) begin
        m_done    = 1'b0;
        m_elapsed = 0;
      end
    end else if (enable_i) begin
      if (!m_run && !m_paused) begin
        m_dir  = dir_i;
        m_mode = mode_i;
      end
      m_run    = 1'b1;
      m_paused = 1'b0;
      if (m_elapsed == m_period) begin
        m_tick = 1'b1;
        if (m_mode) begin
          m_done = 1'b1;
          m_run  = 1'b0;
        end else begin
          m_elapsed = 0;
        end
      end else begin
        m_elapsed++;
      end
    end else if (m_run || m_paused) begin
      m_run = 1'b0;
      if (hold_i) begin
        m_paused = 1'b1;
      end else begin
        m_paused  = 1'b0;
        m_elapsed = 0;
      end
    end
  endtask

  function automatic int model_count();
    return m_dir ? (m_period - m_elapsed) : m_elapsed;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, " count"}, 32'(count_o), 32'(model_count()));
    chk({tag, " tick"},  32'(tick_o),  32'(m_tick));
    chk({tag, " done"},  32'(done_o),  32'(m_done));
    chk({tag, " busy"},  32'(busy_o),  32'(m_run));
  endtask

  // One clock: edge, model update, compare at the falling edge.
  task automatic cycle(string tag);
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    chk_model(tag);
  endtask

  task automatic async_reset(string tag);
    reset_ni = 1'b0;
    #1;
    model_reset();
    chk({tag, " rst count"}, 32'(count_o), 32'd0);
    chk({tag, " rst tick"},  32'(tick_o),  32'd0);
    chk({tag, " rst done"},  32'(done_o),  32'd0);
    chk({tag, " rst busy"},  32'(busy_o),  32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int seen_max;

    // Up, periodic, from reset: 1,2,3,4,0(tick),...
    for (int k = 1; k <= 10; k++) add(1, 0, 0, 0, 0, 1, k % 5, (k % 5 == 0) ? 1 : 0, 0, 1);
    // Down, period 2; later dir_i changes while running are ignored.
    add(1, 1, 2, 1, 0, 1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 1, 0, 1);
    // One-shot period 3, sticky done, reload, exit through clear.
    add(1, 1, 3, 0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 3, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 3, 0, 1, 0);
    add(1, 1, 3, 0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 3, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Pause with hold, then clear without hold.
    add(1, 1, 4, 0, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    // Pause then hold drop clears; restart from IDLE samples dir_i (down from 4).
    add(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    // Period 0: tick every enabled cycle, count stays 0.
    add(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 1, 0, 1, 0, 1);

    reset_ni = 1'b0;
    enable_i = 1'b0;
    load_i   = 1'b0;
    period_i = '0;
    dir_i    = 1'b0;
    mode_i   = 1'b0;
    hold_i   = 1'b1;
    model_reset();
    #12;
    chk("reset count", 32'(count_o), 32'd0);
    chk("reset tick",  32'(tick_o),  32'd0);
    chk("reset done",  32'(done_o),  32'd0);
    chk("reset busy",  32'(busy_o),  32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    foreach (vecs[i]) begin
      enable_i = vecs[i].en;
      load_i   = vecs[i].ld;
      period_i = vecs[i].per;
      dir_i    = vecs[i].dir;
      mode_i   = vecs[i].mode;
      hold_i   = vecs[i].hold;
      cycle($sformatf("vec%0d model", i));
      chk($sformatf("vec%0d count", i), 32'(count_o), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d tick", i),  32'(tick_o),  32'(vecs[i].tick));
      chk($sformatf("vec%0d done", i),  32'(done_o),  32'(vecs[i].done));
      chk($sformatf("vec%0d busy", i),  32'(busy_o),  32'(vecs[i].busy));
    end

    // Full 256-cycle period at period 255, no overflow past 255.
    enable_i = 1'b1; load_i = 1'b1; period_i = 8'd255; dir_i = 1'b0; mode_i = 1'b0; hold_i = 1'b1;
    cycle("p255 load");
    load_i   = 1'b0;
    ticks    = 0;
    seen_max = 0;
    for (int k = 1; k <= 255; k++) begin
      cycle("p255 run");
      ticks += int'(tick_o);
      if (int'(count_o) > seen_max) seen_max = int'(count_o);
    end
    chk("p255 ticks before wrap", 32'(ticks), 32'd0);
    chk("p255 max count", 32'(seen_max), 32'd255);
    cycle("p255 wrap");
    chk("p255 wrap count", 32'(count_o), 32'd0);
    chk("p255 wrap tick",  32'(tick_o),  32'd1);

    // Async reset mid-count restores the default period of 4.
    load_i = 1'b1; period_i = 8'd7;
    cycle("p7 load");
    load_i = 1'b0;
    for (int k = 0; k < 3; k++) cycle("p7 run");
    chk("p7 count before reset", 32'(count_o), 32'd3);
    async_reset("mid");
    ticks = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle("post-reset");
      ticks += int'(tick_o);
    end
    chk("post-reset early ticks", 32'(ticks), 32'd0);
    cycle("post-reset 5th");
    chk("post-reset 5th tick", 32'(tick_o), 32'd1);
    chk("post-reset 5th count", 32'(count_o), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) async_reset("rand");
      enable_i = ($urandom_range(0, 9) != 0);
      load_i   = ($urandom_range(0, 29) == 0);
      period_i = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      dir_i    = 1'($urandom_range(0, 1));
      mode_i   = 1'($urandom_range(0, 1));
      hold_i   = ($urandom_range(0, 3) != 0);
      cycle($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Programmable tick/timer block. It is the parametrised successor of the fixed-terminal enable counter used to pace LED shifting and 7-segment refresh.
- Adds a runtime-loadable period, up/down direction, periodic or one-shot mode, and a pause-vs-clear choice when disabled.
- Sits between the button/enable logic and the LED-sequencer / display blocks, and drives their advance strobes.

Parameters:
- WIDTH, 32, width of the counter and period registers.
- DEFAULT_PERIOD, 25000000, terminal value loaded at reset. Must fit in WIDTH bits.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  count while high.
- load_i  in  1  single-cycle strobe: latch period_i, dir_i and mode_i, then restart.
- period_i  in  WIDTH  new terminal value, sampled on load_i.
- dir_i  in  1  0 = count up, 1 = count down. Sampled on load_i and on IDLE->RUN.
- mode_i  in  1  0 = periodic, 1 = one-shot. Sampled on load_i and on IDLE->RUN.
- hold_i  in  1  behaviour on enable low: 1 = pause (keep count), 0 = clear.
- count_o  out  WIDTH  current count.
- tick_o  out  1  one-cycle terminal pulse.
- done_o  out  1  sticky; high after a one-shot completes.
- busy_o  out  1  high in state RUN.

Behaviour:
- Reset (asynchronous, active-low):
  - period_q = DEFAULT_PERIOD, dir_q = up, mode_q = periodic, state = IDLE.
  - count_o = 0, tick_o = 0, done_o = 0, busy_o = 0.
- Start value: 0 when counting up, period_q when counting down. Terminal value: period_q when counting up, 0 when counting down.
- One period = period_q+1 enabled cycles. period_q = 0 gives tick_o every enabled cycle while count_o stays 0.
- States:
  - IDLE: count_o at start value.
    - enable_i high -> RUN; sample dir_i and mode_i; count steps on that same edge.
  - RUN: count_o steps by 1 each cycle toward the terminal value.
    - At the terminal value, the next edge sets tick_o = 1 for exactly one cycle.
    - Periodic: count_o returns to the start value on that same edge.
    - One-shot: count_o holds the terminal value, done_o = 1, state -> DONE.
    - enable_i low with hold_i = 1 -> PAUSE, count held, tick_o = 0.
    - enable_i low with hold_i = 0 -> IDLE, count reset to start value.
  - PAUSE: count held.
    - enable_i high -> RUN; resumes from the held value with no cycle lost.
    - hold_i dropping to 0 -> IDLE, count cleared.
  - DONE: count_o, done_o and tick_o = 0 held; enable_i high is ignored.
    - Exit only on load_i, or on enable_i low with hold_i = 0 (-> IDLE, done_o cleared).
- load_i has priority over every other input. On the next edge:
  - period_q, dir_q and mode_q update.
  - count_o = start value under the new settings; tick_o = 0; done_o = 0.
  - State -> RUN if enable_i is high, else IDLE. The first step happens on the edge after the load.
- period_q changes only via load_i or reset, so count_o can never pass the terminal value. No wrap beyond period_q in either direction.
- dir_i and mode_i changes in RUN or PAUSE are ignored until the next load_i or IDLE->RUN.
- tick_o is registered; it is never asserted in two consecutive cycles unless period_q = 0.
- Reset mid-operation returns all outputs to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package prog_timer_pkg holds:
  - typedef enum timer_state_e {IDLE, RUN, PAUSE, DONE};
  - constants DIR_UP = 0, DIR_DOWN = 1;
  - constants MODE_PERIODIC = 0, MODE_ONESHOT = 1.
- Single module; no sub-module. The state register and the count/terminal datapath live in one always_ff, with next-state logic in an always_comb.

Test Plan (WIDTH = 8, DEFAULT_PERIOD = 4):
1. Release reset, hold enable_i = 1, up, periodic -> count_o 0,1,2,3,4,0,1…; tick_o high exactly on each cycle count_o returns to 0 (every 5 cycles); busy_o = 1.
2. load_i with period_i = 2, dir_i = 1, enable_i high -> count_o 2,1,0,2,1,0; tick_o on each 0->2 cycle; period of 3 cycles.
3. load_i with period_i = 3, mode_i = 1, up -> count_o 0,1,2,3 then holds 3; one tick_o; done_o = 1. Further enabled cycles give no tick. A new load_i clears done_o and restarts at 0.
4. Periodic, up, drop enable_i at count_o = 2 for 3 cycles:
   - hold_i = 1 -> count_o stays 2, resumes at 3.
   - Repeat with hold_i = 0 -> count_o = 0 while disabled, restarts 0,1,2…
5. load_i with period_i = 0, enable_i high -> tick_o = 1 every cycle, count_o = 0. load_i with period_i = 255, up -> full 256-cycle period with no overflow past 255.
6. Assert reset_ni low mid-count at count_o = 3 after a load of period 7 -> count_o, tick_o, done_o = 0 asynchronously. After release, the period is back to 4 (the next tick comes after 5 enabled cycles).
